fp_div_param: RTL and testbench
===============================

Name: fp_div_param

Overview:
- Parametrised IEEE-754 floating-point divider: computes result = dividend / divisor with one restoring quotient bit per clock.
- Full special-case handling, four rounding modes, and exception flags.
- Successor to the fixed-width single-precision ALU divider.
- Sits in the ALU beside the adder and multiplier behind the same start/busy/valid handshake.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa field width (hidden bit excluded).
- Derived, not overridable: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1; NITER = MAN_W+3.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  request; accepted only in IDLE.
- dividend_i  in  W  operand A; sampled on the accept edge.
- divisor_i  in  W  operand B; sampled on the accept edge.
- rnd_mode_i  in  2  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf); sampled on the accept edge.
- busy_o  out  1  operation in progress.
- valid_o  out  1  one-cycle pulse; result_o and flags_o are valid.
- result_o  out  W  packed IEEE result.
- flags_o  out  5  {invalid, div_by_zero, overflow, underflow, inexact}.

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers cleared. Reset asserted mid-operation aborts the operation with no valid_o pulse.
- States: IDLE -> PREP -> ITER -> ROUND -> IDLE; PREP -> IDLE directly for special cases.
- Accept edge k (IDLE and start_i=1):
  - register operands and mode; busy_o<=1.
  - start_i while busy_o=1 is ignored.
  - start_i in the valid_o cycle is accepted, because the FSM is already in IDLE.
- PREP, edge k+1:
  - Unpack sign, exponent, mantissa. Exponent 0 means zero: subnormal inputs are treated as signed zero (DAZ), with no flag.
  - Classify each operand as zero, normal, inf or NaN.
  - Special-case results, registered at edge k+2 with valid_o=1, busy_o=0:
    - any NaN, 0/0, inf/inf -> canonical qNaN {0, all-ones exp, 1, zeros}, invalid=1.
    - finite nonzero / 0 -> signed inf, div_by_zero=1.
    - inf / finite -> signed inf.
    - 0 / nonzero, finite / inf -> signed zero.
    - Sign is always sA^sB, except qNaN (sign 0).
  - Normal path:
    - significands Ma={1,manA}, Mb={1,manB}.
    - If Ma<Mb: Ma<<=1 and adj=1, else adj=0.
    - Exponent kept signed, EXP_W+2 bits: e = eA - eB + BIAS - adj.
- ITER, NITER cycles (edges k+2..k+NITER+1):
  - Restoring step per cycle: trial = (rem<<1) - Mb. Non-negative -> q bit 1, rem=trial; else q bit 0, rem=rem<<1.
  - The first step uses rem=Ma without the shift.
  - Yields 1 integer bit, MAN_W fraction bits, guard and round bits.
  - sticky = (final rem != 0).
- ROUND, edge k+NITER+2:
  - Apply rnd_mode_i using guard/round/sticky and the sign.
  - Mantissa carry-out -> mantissa 0, e+1.
  - Overflow when e >= 2^EXP_W-1:
    - result is inf for RNE, RUP(+) and RDN(-); otherwise max finite.
    - overflow=1, inexact=1.
  - Underflow when e <= 0: signed zero (flush, FTZ), underflow=1, inexact=1.
  - inexact = guard|round|sticky.
  - Register result_o, flags_o, valid_o=1, busy_o=0.
- Latency:
  - Normal: valid_o rises after edge k+MAN_W+5 (28 cycles at default).
  - Special case: after edge k+2.
- Output hold: result_o and flags_o hold until the next valid_o. valid_o is high exactly one cycle.

Decomposition:
- Shared package fp_div_pkg:
  - rounding-mode localparams RM_RNE/RM_RTZ/RM_RUP/RM_RDN.
  - flag bit indices FLG_NV/FLG_DZ/FLG_OF/FLG_UF/FLG_NX.
  - FSM state encoding.
  - operand class encoding (CLS_ZERO/NORM/INF/NAN).
- Sub-module fp_operand_classify:
  - combinational, parametrised by EXP_W/MAN_W.
  - returns sign, exponent, significand with hidden bit, class.
  - instantiated twice.

Test Plan:
- 0x40C00000 / 0x40000000, RNE -> 0x40400000, flags 0, valid_o exactly 28 cycles after accept, busy_o high throughout.
- 0x3F800000 / 0x40400000 -> RNE 0x3EAAAAAB, RTZ 0x3EAAAAAA; inexact=1 in both.
- 0xBF800000 / 0x00000000 -> 0xFF800000, div_by_zero=1, valid 2 cycles after accept; 0/0 -> 0x7FC00000, invalid=1.
- 0x7F7FFFFF / 0x3F000000 -> RNE 0x7F800000, RTZ 0x7F7FFFFF, overflow=1, inexact=1; 0x00800000 / 0x40000000 -> 0x00000000, underflow=1.
- start_i pulsed at iteration 5 -> ignored, result unchanged; rst_i at iteration 10 -> busy_o=0, valid_o=0 immediately, no pulse; next 6.0/2.0 -> 0x40400000.
- EXP_W=11, MAN_W=52 instance: 0x3FF0000000000000 / 0x4008000000000000 RNE -> 0x3FD5555555555555, valid 57 cycles after accept.

Source files
------------

// File: rtl/fp_div_pkg.sv
// Shared encodings for the parametrised floating-point divider: rounding modes,
// flag bit positions, FSM states and operand classes.
package fp_div_pkg;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RDN = 2'd3;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_PREP, ST_ITER, ST_ROUND} state_e;
  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_e;

endpackage

// File: rtl/fp_operand_classify.sv
// Combinational unpack of one IEEE operand; subnormals (exponent 0) classify as zero.
module fp_operand_classify
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       sig_o,
  output cls_e                 cls_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign sign_o = op_i[EXP_W+MAN_W];
  assign exp_f  = op_i[EXP_W+MAN_W-1:MAN_W];
  assign man_f  = op_i[MAN_W-1:0];
  assign exp_o  = exp_f;
  assign sig_o  = {1'b1, man_f};

  always_comb begin
    cls_o = CLS_NORM;
    if (exp_f == '0)      cls_o = CLS_ZERO;
    else if (exp_f == '1) cls_o = (man_f == '0) ? CLS_INF : CLS_NAN;
  end

endmodule

// File: rtl/fp_div_param.sv
// Restoring IEEE divider, one quotient bit per clock: MAN_W+5 cycles normal, 2 cycles
// for special operands; start_i is only taken in IDLE, otherwise ignored while busy_o.
module fp_div_param
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [EXP_W+MAN_W:0]     dividend_i,
  input  logic [EXP_W+MAN_W:0]     divisor_i,
  input  logic [1:0]               rnd_mode_i,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic [EXP_W+MAN_W:0]     result_o,
  output logic [4:0]               flags_o
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = 2**(EXP_W-1) - 1;
  localparam int NITER = MAN_W + 3;
  localparam int EW    = EXP_W + 2;
  localparam int RW    = MAN_W + 3;
  localparam int CW    = $clog2(NITER + 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, spec_res_q, spec_res_d, res_q, res_d;
  logic [1:0]       rm_q, rm_d;
  logic             spec_q, spec_d, sign_q, sign_d, vld_q, vld_d;
  logic [4:0]       spec_flg_q, spec_flg_d, flg_q, flg_d;
  logic [EW-1:0]    exp_q, exp_d;
  logic [MAN_W:0]   mb_q, mb_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [NITER-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             sgn_a, sgn_b, a_lt_b, is_nan, inc, grd, rnd, stk, lsb, ovf, udf, ovf_inf;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W:0]   sig_a, sig_b, mant_r;
  cls_e             cls_a, cls_b;
  logic [RW-1:0]    ma_n, shifted;
  logic [RW:0]      trial;
  logic [EW-1:0]    exp_n, e_r;

  fp_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op_i(a_q), .sign_o(sgn_a), .exp_o(exp_a), .sig_o(sig_a), .cls_o(cls_a));
  fp_operand_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op_i(b_q), .sign_o(sgn_b), .exp_o(exp_b), .sig_o(sig_b), .cls_o(cls_b));

  // Pre-scale the dividend so the quotient always lands in [1,2).
  assign a_lt_b = sig_a < sig_b;
  assign ma_n   = a_lt_b ? {1'b0, sig_a, 1'b0} : {2'b00, sig_a};
  assign exp_n  = {2'b00, exp_a} - {2'b00, exp_b} + EW'(BIAS) - {{(EW-1){1'b0}}, a_lt_b};
  assign is_nan = (cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
                  (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
                  (cls_a == CLS_INF && cls_b == CLS_INF);

  assign shifted = (cnt_q == '0) ? rem_q : {rem_q[RW-2:0], 1'b0};
  assign trial   = {1'b0, shifted} - {{(RW-MAN_W){1'b0}}, mb_q};

  assign lsb = quo_q[2];
  assign grd = quo_q[1];
  assign rnd = quo_q[0];
  assign stk = |rem_q;

  always_comb begin
    unique case (rm_q)
      RM_RNE:  inc = grd & (rnd | stk | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign_q & (grd | rnd | stk);
      default: inc = sign_q & (grd | rnd | stk);
    endcase
  end

  assign mant_r  = {1'b0, quo_q[NITER-2:2]} + {{MAN_W{1'b0}}, inc};
  assign e_r     = exp_q + {{(EW-1){1'b0}}, mant_r[MAN_W]};
  assign ovf     = !e_r[EW-1] && (e_r >= EMAX);
  assign udf     = e_r[EW-1] || (e_r == '0);
  assign ovf_inf = (rm_q == RM_RNE) || (rm_q == RM_RUP && !sign_q) || (rm_q == RM_RDN && sign_q);

  always_comb begin
    state_d = state_q;  a_d = a_q;  b_d = b_q;  rm_d = rm_q;
    spec_d = spec_q;    spec_res_d = spec_res_q;  spec_flg_d = spec_flg_q;
    sign_d = sign_q;    exp_d = exp_q;  mb_d = mb_q;  rem_d = rem_q;
    quo_d = quo_q;      cnt_d = cnt_q;  res_d = res_q;  flg_d = flg_q;
    vld_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start_i) begin
        a_d = dividend_i;  b_d = divisor_i;  rm_d = rnd_mode_i;
        state_d = ST_PREP;
      end
      ST_PREP: if (!spec_q) begin
        sign_d = sgn_a ^ sgn_b;  mb_d = sig_b;  rem_d = ma_n;  exp_d = exp_n;
        cnt_d = '0;  quo_d = '0;
        spec_flg_d = '0;
        if (is_nan) begin
          spec_res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
          spec_flg_d[FLG_NV] = 1'b1;
        end else if (cls_a == CLS_INF) begin
          spec_res_d = {sgn_a ^ sgn_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_b == CLS_ZERO) begin
          spec_res_d = {sgn_a ^ sgn_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          spec_flg_d[FLG_DZ] = 1'b1;
        end else begin
          spec_res_d = {sgn_a ^ sgn_b, {(W-1){1'b0}}};
        end
        if (cls_a == CLS_NORM && cls_b == CLS_NORM) state_d = ST_ITER;
        else spec_d = 1'b1;
      end else begin
        // Second PREP cycle publishes the special-case result.
        res_d = spec_res_q;  flg_d = spec_flg_q;  vld_d = 1'b1;
        spec_d = 1'b0;  state_d = ST_IDLE;
      end
      ST_ITER: begin
        rem_d = trial[RW] ? shifted : trial[RW-1:0];
        quo_d = {quo_q[NITER-2:0], ~trial[RW]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NITER-1)) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        flg_d = '0;
        if (ovf) begin
          res_d = ovf_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                          : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
          flg_d[FLG_OF] = 1'b1;
          flg_d[FLG_NX] = 1'b1;
        end else if (udf) begin
          res_d = {sign_q, {(W-1){1'b0}}};
          flg_d[FLG_UF] = 1'b1;
          flg_d[FLG_NX] = 1'b1;
        end else begin
          res_d = {sign_q, e_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
          flg_d[FLG_NX] = grd | rnd | stk;
        end
        vld_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;  a_q <= '0;  b_q <= '0;  rm_q <= '0;
      spec_q <= 1'b0;  spec_res_q <= '0;  spec_flg_q <= '0;
      sign_q <= 1'b0;  exp_q <= '0;  mb_q <= '0;  rem_q <= '0;
      quo_q <= '0;  cnt_q <= '0;  res_q <= '0;  flg_q <= '0;  vld_q <= 1'b0;
    end else begin
      state_q <= state_d;  a_q <= a_d;  b_q <= b_d;  rm_q <= rm_d;
      spec_q <= spec_d;  spec_res_q <= spec_res_d;  spec_flg_q <= spec_flg_d;
      sign_q <= sign_d;  exp_q <= exp_d;  mb_q <= mb_d;  rem_q <= rem_d;
      quo_q <= quo_d;  cnt_q <= cnt_d;  res_q <= res_d;  flg_q <= flg_d;  vld_q <= vld_d;
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign valid_o  = vld_q;
  assign result_o = res_q;
  assign flags_o  = flg_q;

endmodule

// File: tb/tb_fp_div_param.sv
// Bench for fp_div_param: directed corner cases, mid-operation start/reset, a double
// precision instance, and random single-precision operands against an exact-division model.
module tb_fp_div_param;

  logic        clk, rst;
  logic        start32, busy32, v32, start64, busy64, v64;
  logic [31:0] a32, b32, r32;
  logic [63:0] a64, b64, r64;
  logic [1:0]  rm32, rm64;
  logic [4:0]  f32, f64;
  int          n_vec, n_err;

  fp_div_param u_dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start32), .dividend_i(a32), .divisor_i(b32),
    .rnd_mode_i(rm32), .busy_o(busy32), .valid_o(v32), .result_o(r32), .flags_o(f32));

  fp_div_param #(.EXP_W(11), .MAN_W(52)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .start_i(start64), .dividend_i(a64), .divisor_i(b64),
    .rnd_mode_i(rm64), .busy_o(busy64), .valid_o(v64), .result_o(r64), .flags_o(f64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact model: truncated 24-bit quotient plus remainder, rounded by comparing the
  // discarded fraction r/mb with one half.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                         output logic [31:0] res, output logic [4:0] fl);
    logic s, za, zb, ia, ib, na, nb, inc;
    int ea, eb, e;
    longint unsigned ma, mb, q, r;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);  eb = int'(b[30:23]);
    za = (ea == 0);  zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);  ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);  nb = (eb == 255) && (b[22:0] != 0);
    fl = 5'b0;
    if (na || nb || (za && zb) || (ia && ib)) begin
      res = 32'h7FC00000;  fl = 5'b10000;
    end else if (ia) res = {s, 8'hFF, 23'h0};
    else if (zb) begin
      res = {s, 8'hFF, 23'h0};  fl = 5'b01000;
    end else if (za || ib) res = {s, 31'h0};
    else begin
      ma = 64'(a[22:0]) + 64'h800000;
      mb = 64'(b[22:0]) + 64'h800000;
      e  = ea - eb + 127;
      if (ma < mb) begin ma = ma * 2; e = e - 1; end
      q = (ma << 23) / mb;
      r = (ma << 23) % mb;
      case (rm)
        2'd0:    inc = (2*r > mb) || ((2*r == mb) && q[0]);
        2'd1:    inc = 1'b0;
        2'd2:    inc = !s && (r != 0);
        default: inc = s && (r != 0);
      endcase
      q = q + 64'(inc);
      if (q == 64'h1000000) begin q = 64'h800000; e = e + 1; end
      if (e >= 255) begin
        res = (rm == 2'd0 || (rm == 2'd2 && !s) || (rm == 2'd3 && s)) ? {s, 8'hFF, 23'h0}
                                                                      : {s, 8'hFE, 23'h7FFFFF};
        fl = 5'b00101;
      end else if (e <= 0) begin
        res = {s, 31'h0};  fl = 5'b00011;
      end else begin
        res = {s, 8'(e), q[22:0]};  fl = {4'b0, r != 0};
      end
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: v[30:0] = '0;
      1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      3: v[30:23] = 8'h00;
      4: v[30:23] = 8'($urandom_range(1, 8));
      5: v[30:23] = 8'($urandom_range(247, 254));
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // inj: 0 none, 1 pulse start_i after edge k+inj_at, 2 assert reset there and return.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                       input int inj, input int inj_at,
                       output logic [31:0] res, output logic [4:0] fl, output int lat);
    int busy_bad;
    busy_bad = 0;  res = '0;  fl = '0;
    @(negedge clk);
    start32 = 1'b1;  a32 = a;  b32 = b;  rm32 = rm;
    @(posedge clk); #1;
    start32 = 1'b0;  lat = 0;
    while (!v32 && lat < 200) begin
      if (!busy32) busy_bad++;
      if (inj == 1 && lat == inj_at) begin
        start32 = 1'b1;  a32 = 32'h40C00000;  b32 = 32'h40000000;  rm32 = 2'd2;
      end
      if (inj == 2 && lat == inj_at) begin
        rst = 1'b1;  #1;
        chk("rst_mid_busy", 64'(busy32), 64'd0);
        chk("rst_mid_valid", 64'(v32), 64'd0);
        return;
      end
      @(posedge clk); #1;
      start32 = 1'b0;  lat++;
    end
    if (lat >= 200) chk("timeout32", 64'd1, 64'd0);
    else begin
      res = r32;  fl = f32;
      chk("busy_through", 64'(busy_bad), 64'd0);
      chk("busy_at_valid", 64'(busy32), 64'd0);
      @(posedge clk); #1;
      chk("valid_one_cycle", 64'(v32), 64'd0);
    end
  endtask

  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic [1:0] rm,
                       output logic [63:0] res, output int lat);
    res = '0;
    @(negedge clk);
    start64 = 1'b1;  a64 = a;  b64 = b;  rm64 = rm;
    @(posedge clk); #1;
    start64 = 1'b0;  lat = 0;
    while (!v64 && lat < 200) begin @(posedge clk); #1; lat++; end
    if (lat >= 200) chk("timeout64", 64'd1, 64'd0);
    else res = r64;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  rm;
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
  } dvec_t;

  dvec_t dir[8] = '{
    '{32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, 28},
    '{32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB, 5'b00001, 28},
    '{32'h3F800000, 32'h40400000, 2'd1, 32'h3EAAAAAA, 5'b00001, 28},
    '{32'hBF800000, 32'h00000000, 2'd0, 32'hFF800000, 5'b01000, 2},
    '{32'h00000000, 32'h00000000, 2'd0, 32'h7FC00000, 5'b10000, 2},
    '{32'h7F7FFFFF, 32'h3F000000, 2'd0, 32'h7F800000, 5'b00101, 28},
    '{32'h7F7FFFFF, 32'h3F000000, 2'd1, 32'h7F7FFFFF, 5'b00101, 28},
    '{32'h00800000, 32'h40000000, 2'd0, 32'h00000000, 5'b00011, 28}
  };

  initial begin
    logic [31:0] res, er, a, b;
    logic [63:0] res64;
    logic [4:0]  fl, ef;
    logic [1:0]  rm;
    int          lat, pulses, elat;
    n_vec = 0;  n_err = 0;
    rst = 1'b1;  start32 = 1'b0;  start64 = 1'b0;
    a32 = '0;  b32 = '0;  rm32 = '0;  a64 = '0;  b64 = '0;  rm64 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_result", 64'(r32), 64'd0);
    chk("reset_flags", 64'(f32), 64'd0);
    chk("reset_valid", 64'(v32), 64'd0);
    chk("reset_busy", 64'(busy32), 64'd0);
    chk("reset_result64", r64, 64'd0);

    foreach (dir[i]) begin
      run32(dir[i].a, dir[i].b, dir[i].rm, 0, 0, res, fl, lat);
      chk($sformatf("dir%0d_result", i), 64'(res), 64'(dir[i].res));
      chk($sformatf("dir%0d_flags", i), 64'(fl), 64'(dir[i].fl));
      chk($sformatf("dir%0d_latency", i), 64'(lat), 64'(dir[i].lat));
    end

    run32(32'h3F800000, 32'h40400000, 2'd0, 1, 5, res, fl, lat);
    chk("start_ignored_result", 64'(res), 64'h3EAAAAAB);
    chk("start_ignored_latency", 64'(lat), 64'd28);

    run32(32'h3F800000, 32'h40400000, 2'd0, 2, 10, res, fl, lat);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_result", 64'(r32), 64'd0);
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (v32) pulses++; end
    chk("rst_mid_no_pulse", 64'(pulses), 64'd0);
    run32(32'h40C00000, 32'h40000000, 2'd0, 0, 0, res, fl, lat);
    chk("after_rst_result", 64'(res), 64'h40400000);

    run64(64'h3FF0000000000000, 64'h4008000000000000, 2'd0, res64, lat);
    chk("dp_third_result", res64, 64'h3FD5555555555555);
    chk("dp_third_latency", 64'(lat), 64'd57);
    run64(64'h4018000000000000, 64'h4000000000000000, 2'd0, res64, lat);
    chk("dp_three_result", res64, 64'h4008000000000000);

    for (int i = 0; i < 100; i++) begin
      a  = rnd_op();
      b  = rnd_op();
      rm = 2'($urandom_range(0, 3));
      ref_div(a, b, rm, er, ef);
      elat = (a[30:23] != 8'h00 && a[30:23] != 8'hFF &&
              b[30:23] != 8'h00 && b[30:23] != 8'hFF) ? 28 : 2;
      run32(a, b, rm, 0, 0, res, fl, lat);
      chk($sformatf("rnd%0d_result %h/%h rm%0d", i, a, b, rm), 64'(res), 64'(er));
      chk($sformatf("rnd%0d_flags", i), 64'(fl), 64'(ef));
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(elat));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
